sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 99 +++++++++
 tb/tb_sw_debounce.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: 4-channel switch debouncer with synchronizer, sample
// prescaler, per-channel stability qualification and edge/toggle outputs.
module sw_debounce #(
    parameter int CLK_HZ     = 5_000_000,
    parameter int SAMPLE_HZ  = 1_000,
    parameter int STABLE_CNT = 10
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] sw,
    output logic [3:0] sw_db,
    output logic [3:0] sw_rise,
    output logic [3:0] sw_fall,
    output logic [3:0] sw_toggle,
    output logic       tick
);

    localparam int NCH = 4;
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW_ = $clog2(STABLE_CNT + 1);
    localparam int SCW = (SW_ > 0) ? SW_ : 1;

    localparam logic [PW-1:0]  PRE_LAST  = PW'(DIV - 1);
    localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CNT - 1);

    logic [3:0]     sync_q1;
    logic [3:0]     sync;
    logic [PW-1:0]  pre_cnt;
    logic [SCW-1:0] stab_cnt [NCH];
    logic [3:0]     diff;
    logic [3:0]     qual;

    // Two-flop synchronizer; only the second stage feeds the logic
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync    <= '0;
        end else begin
            sync_q1 <= sw;
            sync    <= sync_q1;
        end
    end

    // Sample prescaler counting 0..DIV-1 and wrapping
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

    // Per-channel qualification: a differing sample on the last count wins
    always_comb begin
        diff = sync ^ sw_db;
        qual = '0;
        for (int i = 0; i < NCH; i++) begin
            qual[i] = tick && diff[i] && (stab_cnt[i] == STAB_LAST);
        end
    end

    // Stability counters advance only on ticks; any agreeing sample clears
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                stab_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NCH; i++) begin
                if (!diff[i] || qual[i]) begin
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + SCW'(1);
                end
            end
        end
    end

    // Debounced level, one-cycle edge pulses and rise-driven toggle
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sw_db     <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            sw_toggle <= '0;
        end else begin
            sw_db     <= sw_db ^ qual;
            sw_rise   <= qual & sync;
            sw_fall   <= qual & ~sync;
            sw_toggle <= sw_toggle ^ (qual & sync);
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of sw_debounce with DIV=10, STABLE_CNT=3.
// Each scenario task drives stimulus and compares against hand-derived values.
module tb_sw_debounce;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] sw     = '0;
    logic [3:0] sw_db;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;
    logic [3:0] sw_toggle;
    logic       tick;

    int checks = 0;
    int errors = 0;

    sw_debounce #(
        .CLK_HZ(100),
        .SAMPLE_HZ(10),
        .STABLE_CNT(3)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .sw(sw),
        .sw_db(sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_toggle(sw_toggle),
        .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst = 1'b1;
        sw  = 4'hF;
        repeat (4) step();
        checks++;
        if (sw_db !== 4'h0) begin
            errors++;
            $display("FAIL reset_db got=%h exp=0", sw_db);
        end
        checks++;
        if (sw_rise !== 4'h0) begin
            errors++;
            $display("FAIL reset_rise got=%h exp=0", sw_rise);
        end
        checks++;
        if (sw_fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_fall got=%h exp=0", sw_fall);
        end
        checks++;
        if (sw_toggle !== 4'h0) begin
            errors++;
            $display("FAIL reset_toggle got=%h exp=0", sw_toggle);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got=%b exp=0", tick);
        end
    endtask

    task automatic test_tick();
        logic exp_tick;
        sw  = 4'h0;
        rst = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            step();
            exp_tick = ((i % 10) == 9);
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL tick_cycle%0d got=%b exp=%b",
                         i, tick, exp_tick);
            end
            checks++;
            if ((sw_db | sw_rise | sw_fall | sw_toggle) !== 4'h0) begin
                errors++;
                $display("FAIL idle_outputs cycle%0d db=%h r=%h f=%h t=%h",
                         i, sw_db, sw_rise, sw_fall, sw_toggle);
            end
        end
    endtask

    task automatic test_clean_step();
        int n;
        n  = 0;
        sw = 4'b0001;
        while (sw_db[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n < 23 || n > 32) begin
            errors++;
            $display("FAIL step_latency got=%0d exp=23..32", n);
        end
        checks++;
        if (sw_rise !== 4'b0001 || sw_fall !== 4'b0000) begin
            errors++;
            $display("FAIL step_edges rise=%h fall=%h exp rise=1 fall=0",
                     sw_rise, sw_fall);
        end
        checks++;
        if (sw_toggle !== 4'b0001) begin
            errors++;
            $display("FAIL step_toggle got=%h exp=1", sw_toggle);
        end
        step();
        checks++;
        if (sw_rise !== 4'b0000 || sw_db !== 4'b0001) begin
            errors++;
            $display("FAIL step_pulse_width rise=%h db=%h exp rise=0 db=1",
                     sw_rise, sw_db);
        end
    endtask

    task automatic test_bounce();
        int bad;
        int rises;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            sw[1] = (((i / 7) % 2) == 0);
            step();
            if (sw_db[1] !== 1'b0 || sw_rise[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_glitch got=%0d bad cycles exp=0", bad);
        end
        sw[1] = 1'b1;
        rises = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sw_rise[1] === 1'b1) rises++;
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL bounce_rises got=%0d exp=1", rises);
        end
        checks++;
        if (sw_db !== 4'b0011) begin
            errors++;
            $display("FAIL bounce_db got=%h exp=3", sw_db);
        end
    endtask

    task automatic test_all_step();
        int n;
        do_reset();
        sw = 4'hF;
        n  = 0;
        while (sw_db === 4'h0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sw_db !== 4'hF) begin
            errors++;
            $display("FAIL all_db got=%h exp=f", sw_db);
        end
        checks++;
        if (sw_rise !== 4'hF || sw_fall !== 4'h0) begin
            errors++;
            $display("FAIL all_edges rise=%h fall=%h exp rise=f fall=0",
                     sw_rise, sw_fall);
        end
        checks++;
        if (sw_toggle !== 4'hF) begin
            errors++;
            $display("FAIL all_toggle got=%h exp=f", sw_toggle);
        end
    endtask

    task automatic test_toggle_fall();
        int n;
        do_reset();
        sw = 4'b0100;
        n  = 0;
        while (sw_db[2] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sw_toggle !== 4'b0100) begin
            errors++;
            $display("FAIL press1_toggle got=%h exp=4", sw_toggle);
        end
        sw = 4'b0000;
        n  = 0;
        while (sw_db[2] !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sw_fall !== 4'b0100 || sw_rise !== 4'b0000) begin
            errors++;
            $display("FAIL release_edges fall=%h rise=%h exp fall=4 rise=0",
                     sw_fall, sw_rise);
        end
        checks++;
        if (sw_toggle !== 4'b0100) begin
            errors++;
            $display("FAIL release_toggle got=%h exp=4", sw_toggle);
        end
        step();
        checks++;
        if (sw_fall !== 4'b0000) begin
            errors++;
            $display("FAIL fall_width got=%h exp=0", sw_fall);
        end
        sw = 4'b0100;
        n  = 0;
        while (sw_db[2] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sw_toggle !== 4'b0000 || sw_rise !== 4'b0100) begin
            errors++;
            $display("FAIL press2 toggle=%h rise=%h exp toggle=0 rise=4",
                     sw_toggle, sw_rise);
        end
    endtask

    task automatic test_reset_mid();
        int tk;
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sw  = 4'b1000;
        tk  = 0;
        n   = 0;
        while (tk < 2 && n < 40) begin
            step();
            n++;
            if (tick === 1'b1) tk++;
        end
        step();
        checks++;
        if (sw_db !== 4'h0 || tk != 2) begin
            errors++;
            $display("FAIL mid_pre db=%h ticks=%0d exp db=0 ticks=2",
                     sw_db, tk);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({sw_db, sw_rise, sw_fall, sw_toggle, tick} !== 17'h0) begin
            errors++;
            $display("FAIL mid_in_reset db=%h r=%h f=%h t=%h tick=%b exp=0",
                     sw_db, sw_rise, sw_fall, sw_toggle, tick);
        end
        rst = 1'b0;
        n   = 0;
        while (sw_rise[3] !== 1'b1 && sw_db[3] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n != 30) begin
            errors++;
            $display("FAIL mid_requal_cycles got=%0d exp=30", n);
        end
        checks++;
        if (sw_rise !== 4'b1000 || sw_db !== 4'b1000 ||
            sw_toggle !== 4'b1000) begin
            errors++;
            $display("FAIL mid_requal rise=%h db=%h tog=%h exp 8/8/8",
                     sw_rise, sw_db, sw_toggle);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_clean_step();
        test_bounce();
        test_all_step();
        test_toggle_fall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
